// File: rtl/uart_rx_frame_checker.sv
// rtl/uart_rx_frame_checker.sv - UART frame checker with first-word-fall-through error-flag FIFO
//
// Checks start/stop/parity of each completed 11-bit frame and queues
// {par_err, frm_err, data} for a valid/ready consumer.
// Ports:
//   baud_clk, rst_n         clock, asynchronous active-low reset
//   frame_in[10:0]          {stop, parity, D7..D0, start}
//   frame_valid             frame_in holds a completed frame (may stay high)
//   rx_data/rx_par_err/rx_frm_err  head entry of the FIFO
//   rx_valid, rx_ready      consumer handshake
//   overrun_err, err_clr    sticky drop flag and its synchronous clear
//   fifo_count              current occupancy
module uart_rx_frame_checker #(
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          baud_clk,
  input  logic          rst_n,
  input  logic [10:0]   frame_in,
  input  logic          frame_valid,
  output logic [7:0]    rx_data,
  output logic          rx_par_err,
  output logic          rx_frm_err,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          overrun_err,
  input  logic          err_clr,
  output logic [CW-1:0] fifo_count
);

  logic          fv_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    mem_data [FIFO_DEPTH];
  logic          mem_par  [FIFO_DEPTH];
  logic          mem_frm  [FIFO_DEPTH];

  logic capture;
  logic full;
  logic pop;
  logic push;
  logic frm_err_c;
  logic par_err_c;

  always_comb begin
    capture   = frame_valid && !fv_q;
    full      = (count == CW'(FIFO_DEPTH));
    pop       = (count != '0) && rx_ready;
    // A pop in the same cycle frees the head slot, which is exactly the slot
    // the write pointer points at when full, so the push can proceed.
    push      = capture && (!full || pop);
    frm_err_c = frame_in[0] || !frame_in[10];
    par_err_c = (PARITY_EN != 0) && ((^frame_in[9:1]) != (PARITY_ODD != 0));
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      // History starts high so a frame already present at release is ignored.
      fv_q        <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= 8'h00;
        mem_par[i]  <= 1'b0;
        mem_frm[i]  <= 1'b0;
      end
    end else begin
      fv_q <= frame_valid;
      if (push) begin
        mem_data[wr_ptr] <= frame_in[8:1];
        mem_par[wr_ptr]  <= par_err_c;
        mem_frm[wr_ptr]  <= frm_err_c;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Setting wins over a simultaneous clear.
      if (capture && full && !pop) begin
        overrun_err <= 1'b1;
      end else if (err_clr) begin
        overrun_err <= 1'b0;
      end
    end
  end

  assign rx_data    = mem_data[rd_ptr];
  assign rx_par_err = mem_par[rd_ptr];
  assign rx_frm_err = mem_frm[rd_ptr];
  assign rx_valid   = (count != '0);
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// tb/tb_uart_rx_frame_checker.sv - scoreboard testbench for uart_rx_frame_checker
module tb_uart_rx_frame_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] frame_in;
  logic        frame_valid;
  logic [7:0]  rx_data;
  logic        rx_par_err;
  logic        rx_frm_err;
  logic        rx_valid;
  logic        rx_ready;
  logic        overrun_err;
  logic        err_clr;
  logic [2:0]  fifo_count;

  logic [7:0]  o_data;
  logic        o_par_err;
  logic        o_frm_err;
  logic        o_valid;
  logic        o_overrun;
  logic [2:0]  o_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_frame_checker #(.PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut (
    .baud_clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid(frame_valid),
    .rx_data(rx_data), .rx_par_err(rx_par_err), .rx_frm_err(rx_frm_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun_err(overrun_err),
    .err_clr(err_clr), .fifo_count(fifo_count)
  );

  // Odd-parity instance with an always-ready consumer: its head shows each
  // captured frame for one cycle.
  uart_rx_frame_checker #(.PARITY_EN(1), .PARITY_ODD(1), .FIFO_DEPTH(4)) dut_odd (
    .baud_clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid(frame_valid),
    .rx_data(o_data), .rx_par_err(o_par_err), .rx_frm_err(o_frm_err),
    .rx_valid(o_valid), .rx_ready(1'b1), .overrun_err(o_overrun),
    .err_clr(err_clr), .fifo_count(o_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par,
                                     input logic start, input logic stop);
    return {stop, par, d, start};
  endfunction

  // Even-parity-correct frame.
  function automatic logic [10:0] good(input logic [7:0] d);
    return mk(d, ^d, 1'b0, 1'b1);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Raise frame_valid for 'hold' cycles, then drop it for one cycle.
  task automatic send(input logic [10:0] f, input int hold);
    frame_in    = f;
    frame_valid = 1'b1;
    repeat (hold) cyc();
    frame_valid = 1'b0;
    cyc();
  endtask

  task automatic drain();
    int n;
    n = 0;
    rx_ready = 1'b1;
    while (rx_valid && n < 50) begin
      cyc();
      n++;
    end
    chk("drain_timeout", {31'd0, rx_valid}, 32'd0);
    rx_ready = 1'b0;
  endtask

  // Monitor: compares the head against the scoreboard on every accepted
  // transfer and checks the head is stable across stalled cycles.
  logic       stalled = 1'b0;
  logic [9:0] stall_val;
  always @(negedge clk) begin
    logic [9:0] head;
    logic [9:0] e;
    head = {rx_par_err, rx_frm_err, rx_data};
    if (!rst_n || !rx_valid) begin
      stalled = 1'b0;
    end else begin
      if (stalled) chk("stall_hold", {22'd0, head}, {22'd0, stall_val});
      if (rx_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %0h expected none", head);
        end else begin
          e = exp_q.pop_front();
          chk("pop_entry", {22'd0, head}, {22'd0, e});
        end
      end else begin
        stalled   = 1'b1;
        stall_val = head;
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    frame_in    = good(8'h55);
    frame_valid = 1'b1;
    rx_ready    = 1'b0;
    err_clr     = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_overrun", {31'd0, overrun_err}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_flags", {30'd0, rx_par_err, rx_frm_err}, 32'd0);

    // frame_valid high across release must not capture.
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("no_capture_at_release", {29'd0, fifo_count}, 32'd0);
    frame_valid = 1'b0;
    cyc();

    // Good frame held for 3 cycles -> one entry.
    frame_in    = 11'b1_0_10100101_0;
    frame_valid = 1'b1;
    exp_q.push_back({2'b00, 8'hA5});
    cyc();
    @(negedge clk);
    chk("good_valid", {31'd0, rx_valid}, 32'd1);
    chk("good_data", {24'd0, rx_data}, 32'hA5);
    chk("good_flags", {30'd0, rx_par_err, rx_frm_err}, 32'd0);
    chk("good_count", {29'd0, fifo_count}, 32'd1);
    cyc();
    cyc();
    frame_valid = 1'b0;
    cyc();
    chk("held_single_capture", {29'd0, fifo_count}, 32'd1);
    drain();

    // Error flags.
    rx_ready = 1'b1;
    frame_in    = mk(8'h01, 1'b0, 1'b0, 1'b1);
    frame_valid = 1'b1;
    exp_q.push_back({2'b10, 8'h01});
    cyc();
    @(negedge clk);
    chk("odd_valid", {31'd0, o_valid}, 32'd1);
    chk("odd_data", {24'd0, o_data}, 32'h01);
    chk("odd_par_err", {31'd0, o_par_err}, 32'd0);
    cyc();
    frame_valid = 1'b0;
    cyc();
    exp_q.push_back({2'b01, 8'h3C});
    send(mk(8'h3C, 1'b0, 1'b1, 1'b1), 1);
    exp_q.push_back({2'b01, 8'h3C});
    send(mk(8'h3C, 1'b0, 1'b0, 1'b0), 1);
    drain();

    // Overflow: five frames into depth 4.
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back({2'b00, 8'(i)});
      send(good(8'(i)), 1);
    end
    chk("ovf_count", {29'd0, fifo_count}, 32'd4);
    chk("ovf_overrun", {31'd0, overrun_err}, 32'd1);
    drain();
    chk("ovf_queue_empty", exp_q.size(), 32'd0);
    chk("ovf_sticky", {31'd0, overrun_err}, 32'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overrun_err}, 32'd0);

    // Full with a simultaneous pop.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'b00, 8'(8'h10 + i)});
      send(good(8'(8'h10 + i)), 1);
    end
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    frame_in    = good(8'h14);
    frame_valid = 1'b1;
    rx_ready    = 1'b1;
    exp_q.push_back({2'b00, 8'h14});
    cyc();
    rx_ready    = 1'b0;
    frame_valid = 1'b0;
    @(negedge clk);
    chk("fullpop_count", {29'd0, fifo_count}, 32'd4);
    chk("fullpop_overrun", {31'd0, overrun_err}, 32'd0);
    cyc();
    drain();

    // Wrap-around with random backpressure; a pop opportunity every other
    // cycle keeps the FIFO from overflowing.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({2'b00, 8'(8'h40 + i * 7)});
      frame_in    = good(8'(8'h40 + i * 7));
      frame_valid = 1'b1;
      rx_ready    = 1'($urandom_range(0, 1));
      cyc();
      frame_valid = 1'b0;
      rx_ready    = 1'b1;
      cyc();
    end
    rx_ready = 1'b0;
    cyc();
    drain();
    chk("wrap_queue_empty", exp_q.size(), 32'd0);

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b00, 8'(8'h60 + i)});
      send(good(8'(8'h60 + i)), 1);
    end
    chk("pre_reset_count", {29'd0, fifo_count}, 32'd3);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    frame_in    = good(8'h77);
    frame_valid = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, rx_valid}, 32'd0);
    chk("midrst_count", {29'd0, fifo_count}, 32'd0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("midrst_no_capture", {29'd0, fifo_count}, 32'd0);
    frame_valid = 1'b0;
    cyc();
    exp_q.push_back({2'b00, 8'h77});
    send(good(8'h77), 2);
    chk("post_rst_count", {29'd0, fifo_count}, 32'd1);
    drain();

    repeat (3) cyc();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
